// File: rtl/sw_rxbuf_pkg.sv
// rtl/sw_rxbuf_pkg.sv - shared types and defaults for the RX buffer read scheduler
package sw_rxbuf_pkg;
  localparam int FLOWS_DFLT      = 4;
  localparam int BLOCK_SIZE_DFLT = 64;
  localparam int CNT_WIDTH_DFLT  = $clog2(BLOCK_SIZE_DFLT) + 1;
  localparam int IFC_WIDTH       = $clog2(FLOWS_DFLT);
  localparam int STAT_WIDTH      = 32;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } sched_state_e;
endpackage

// File: rtl/sw_rxbuf_rr_pick.sv
// rtl/sw_rxbuf_rr_pick.sv - combinational round-robin pick starting at the pointer
module sw_rxbuf_rr_pick #(
  parameter int FLOWS = 4,
  parameter int IW    = $clog2(FLOWS)
) (
  input  logic [FLOWS-1:0] elig_i,
  input  logic [IW-1:0]    ptr_i,
  output logic [FLOWS-1:0] pick_o,
  output logic [IW-1:0]    pick_idx_o,
  output logic             any_o
);

  always_comb begin
    logic [IW-1:0] idx;
    logic          found;
    found      = 1'b0;
    idx        = '0;
    pick_idx_o = '0;
    // FLOWS is a power of two, so IW-bit addition wraps the scan for free
    for (int i = 0; i < FLOWS; i++) begin
      idx = ptr_i + IW'(i);
      if (!found && elig_i[idx]) begin
        found      = 1'b1;
        pick_idx_o = idx;
      end
    end
    pick_o = found ? (FLOWS'(1) << pick_idx_o) : '0;
    any_o  = found;
  end

endmodule

// File: rtl/sw_rxbuf_rd_sched.sv
// rtl/sw_rxbuf_rd_sched.sv - packet-granular round-robin read scheduler; SW_RXBUF_SCHED_STAT_EN adds served-packet counters
module sw_rxbuf_rd_sched
  import sw_rxbuf_pkg::*;
#(
  parameter int FLOWS      = FLOWS_DFLT,
  parameter int BLOCK_SIZE = BLOCK_SIZE_DFLT,
  parameter int CNT_WIDTH  = $clog2(BLOCK_SIZE) + 1
) (
  input  logic                          CLK,
  input  logic                          RESET_N,
  input  logic [FLOWS-1:0]              FLOW_EN,
  input  logic [FLOWS-1:0]              PKT_DONE,
  input  logic                          RD_REQ,
  input  logic                          RD_EOP,
  output logic                          RD_VLD,
  output logic [FLOWS-1:0]              RD_GRANT,
  output logic [$clog2(FLOWS)-1:0]      RD_IFC,
  output logic [FLOWS*CNT_WIDTH-1:0]    PKT_CNT,
  output logic [FLOWS-1:0]              ERR,
  input  logic                          STAT_CLR,
  output logic [FLOWS*STAT_WIDTH-1:0]   STAT_PKTS
);

  localparam int IW = $clog2(FLOWS);

  sched_state_e         state_q, state_d;
  logic [FLOWS-1:0]     grant_q, grant_d;
  logic [IW-1:0]        ifc_q, ifc_d;
  logic [IW-1:0]        ptr_q, ptr_d;
  logic [CNT_WIDTH-1:0] cnt_q [FLOWS];
  logic [FLOWS-1:0]     err_q;
  logic [FLOWS-1:0]     elig;
  logic [FLOWS-1:0]     pick;
  logic [IW-1:0]        pick_idx;
  logic                 pick_any;
  logic                 eop_fire;

  always_comb begin
    for (int i = 0; i < FLOWS; i++) begin
      elig[i] = FLOW_EN[i] && (cnt_q[i] != '0);
    end
  end

  sw_rxbuf_rr_pick #(.FLOWS(FLOWS), .IW(IW)) u_pick (
    .elig_i     (elig),
    .ptr_i      (ptr_q),
    .pick_o     (pick),
    .pick_idx_o (pick_idx),
    .any_o      (pick_any)
  );

  assign eop_fire = (state_q == GRANT) && RD_EOP;

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ifc_d   = ifc_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE: begin
        if (RD_REQ && pick_any) begin
          grant_d = pick;
          ifc_d   = pick_idx;
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (RD_EOP) begin
          ptr_d   = ifc_q + IW'(1);
          grant_d = '0;
          ifc_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= IDLE;
      grant_q <= '0;
      ifc_q   <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ifc_q   <= ifc_d;
      ptr_q   <= ptr_d;
    end
  end

  // A completion and a drain on the same flow in one cycle cancel out
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      cnt_q <= '{default: '0};
      err_q <= '0;
    end else begin
      for (int i = 0; i < FLOWS; i++) begin
        if (PKT_DONE[i] && !(eop_fire && ifc_q == IW'(i))) begin
          if (cnt_q[i] == CNT_WIDTH'(BLOCK_SIZE)) begin
            err_q[i] <= 1'b1;
          end else begin
            cnt_q[i] <= cnt_q[i] + CNT_WIDTH'(1);
          end
        end else if (!PKT_DONE[i] && eop_fire && ifc_q == IW'(i)) begin
          cnt_q[i] <= cnt_q[i] - CNT_WIDTH'(1);
        end
      end
    end
  end

  for (genvar g = 0; g < FLOWS; g++) begin : g_cnt_out
    assign PKT_CNT[g*CNT_WIDTH +: CNT_WIDTH] = cnt_q[g];
  end

  assign RD_VLD   = (state_q == GRANT);
  assign RD_GRANT = grant_q;
  assign RD_IFC   = ifc_q;
  assign ERR      = err_q;

`ifdef SW_RXBUF_SCHED_STAT_EN
  logic [STAT_WIDTH-1:0] stat_q [FLOWS];

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      stat_q <= '{default: '0};
    end else if (STAT_CLR) begin
      stat_q <= '{default: '0};
    end else if (eop_fire) begin
      stat_q[ifc_q] <= stat_q[ifc_q] + STAT_WIDTH'(1);
    end
  end

  for (genvar g = 0; g < FLOWS; g++) begin : g_stat_out
    assign STAT_PKTS[g*STAT_WIDTH +: STAT_WIDTH] = stat_q[g];
  end
`else
  logic unused_stat_clr;
  assign unused_stat_clr = STAT_CLR;
  assign STAT_PKTS       = '0;
`endif

endmodule

// File: tb/tb_sw_rxbuf_rd_sched.sv
// tb/tb_sw_rxbuf_rd_sched.sv - scoreboard bench for the RX buffer read scheduler
module tb_sw_rxbuf_rd_sched;
  localparam int FLOWS = 4;
  localparam int CW    = 7;
  localparam int SW    = 32;

  logic                  CLK = 1'b0;
  logic                  RESET_N = 1'b0;
  logic [FLOWS-1:0]      FLOW_EN = 4'hF;
  logic [FLOWS-1:0]      PKT_DONE = '0;
  logic                  RD_REQ = 1'b0;
  logic                  RD_EOP = 1'b0;
  logic                  RD_VLD;
  logic [FLOWS-1:0]      RD_GRANT;
  logic [1:0]            RD_IFC;
  logic [FLOWS*CW-1:0]   PKT_CNT;
  logic [FLOWS-1:0]      ERR;
  logic                  STAT_CLR = 1'b0;
  logic [FLOWS*SW-1:0]   STAT_PKTS;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_q[$];
  logic prev_vld = 1'b0;

  always #5 CLK = ~CLK;

  sw_rxbuf_rd_sched dut (
    .CLK(CLK), .RESET_N(RESET_N), .FLOW_EN(FLOW_EN), .PKT_DONE(PKT_DONE),
    .RD_REQ(RD_REQ), .RD_EOP(RD_EOP), .RD_VLD(RD_VLD), .RD_GRANT(RD_GRANT),
    .RD_IFC(RD_IFC), .PKT_CNT(PKT_CNT), .ERR(ERR), .STAT_CLR(STAT_CLR),
    .STAT_PKTS(STAT_PKTS)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Every new grant must match the next expected flow in the scoreboard
  always @(negedge CLK) begin
    if (RD_VLD && !prev_vld) begin
      if (exp_q.size() == 0) begin
        check("unexp_grant", 64'(exp_q.size()), 64'd1);
      end else begin
        int e;
        e = exp_q.pop_front();
        check("grant_ifc", 64'(RD_IFC), 64'(e));
        check("grant_onehot", 64'(RD_GRANT), 64'(1 << e));
      end
    end
    prev_vld = RD_VLD;
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RESET_N = 1'b0;
    repeat (2) tick();
    RESET_N = 1'b1;
    tick();
  endtask

  task automatic pkt_done(input logic [FLOWS-1:0] m);
    PKT_DONE = m;
    tick();
    PKT_DONE = '0;
  endtask

  task automatic wait_grant();
    int t = 0;
    while (!RD_VLD && t < 50) begin
      tick();
      t++;
    end
    if (!RD_VLD) check("grant_timeout", 64'(RD_VLD), 64'd1);
  endtask

  task automatic eop();
    RD_EOP = 1'b1;
    tick();
    RD_EOP = 1'b0;
  endtask

  function automatic logic [63:0] stat3();
    return 64'(STAT_PKTS[3*SW +: SW]);
  endfunction

  initial begin
    logic [31:0] stat_exp;
    // reset and idle
    repeat (10) tick();
    check("rst_vld", 64'(RD_VLD), 64'd0);
    check("rst_grant", 64'(RD_GRANT), 64'd0);
    check("rst_ifc", 64'(RD_IFC), 64'd0);
    check("rst_cnt", 64'(PKT_CNT), 64'd0);
    check("rst_err", 64'(ERR), 64'd0);
    check("rst_stat", 64'(STAT_PKTS[63:0]), 64'd0);
    RESET_N = 1'b1;
    RD_REQ = 1'b1;
    repeat (5) tick();
    check("idle_vld", 64'(RD_VLD), 64'd0);
    check("idle_cnt", 64'(PKT_CNT), 64'd0);
    RD_REQ = 1'b0;

    // single flow, latency and count tracking
    pkt_done(4'b0100);
    pkt_done(4'b0100);
    check("sf_cnt2", 64'(PKT_CNT), 64'd2 << 14);
    exp_q.push_back(2);
    RD_REQ = 1'b1;
    tick();
    check("sf_latency", 64'(RD_VLD), 64'd1);
    RD_REQ = 1'b0;
    eop();
    check("sf_vld_after_eop", 64'(RD_VLD), 64'd0);
    check("sf_cnt1", 64'(PKT_CNT), 64'd1 << 14);
    exp_q.push_back(2);
    RD_REQ = 1'b1;
    wait_grant();
    RD_REQ = 1'b0;
    eop();
    check("sf_cnt0", 64'(PKT_CNT), 64'd0);

    // round robin across all flows
    do_reset();
    repeat (3) pkt_done(4'hF);
    for (int r = 0; r < 3; r++)
      for (int f = 0; f < FLOWS; f++) exp_q.push_back(f);
    RD_REQ = 1'b1;
    for (int k = 0; k < 12; k++) begin
      wait_grant();
      eop();
      check("rr_gap", 64'(RD_VLD), 64'd0);
    end
    RD_REQ = 1'b0;
    tick();
    check("rr_cnt", 64'(PKT_CNT), 64'd0);

    // enable mask
    do_reset();
    FLOW_EN = 4'b1010;
    pkt_done(4'hF);
    exp_q.push_back(1);
    exp_q.push_back(3);
    RD_REQ = 1'b1;
    repeat (2) begin
      wait_grant();
      eop();
    end
    repeat (10) tick();
    check("mask_no_grant", 64'(RD_VLD), 64'd0);
    RD_REQ = 1'b0;
    check("mask_cnt", 64'(PKT_CNT), 64'd1 | (64'd1 << 14));
    FLOW_EN = 4'hF;

    // simultaneous increment/decrement, then overflow
    do_reset();
    pkt_done(4'b0010);
    exp_q.push_back(1);
    RD_REQ = 1'b1;
    wait_grant();
    RD_REQ = 1'b0;
    RD_EOP = 1'b1;
    PKT_DONE = 4'b0010;
    tick();
    RD_EOP = 1'b0;
    PKT_DONE = '0;
    check("sim_cnt1", 64'(PKT_CNT), 64'd1 << 7);
    repeat (64) pkt_done(4'b0001);
    check("ovf_cnt_full", 64'(PKT_CNT[CW-1:0]), 64'd64);
    check("ovf_err_none", 64'(ERR), 64'd0);
    pkt_done(4'b0001);
    check("ovf_cnt_sat", 64'(PKT_CNT), 64'd64 | (64'd1 << 7));
    check("ovf_err", 64'(ERR), 64'b0001);
    repeat (3) tick();
    check("ovf_err_sticky", 64'(ERR), 64'b0001);

    // statistics
    do_reset();
    repeat (5) pkt_done(4'b1000);
    for (int k = 0; k < 5; k++) exp_q.push_back(3);
    RD_REQ = 1'b1;
    repeat (5) begin
      wait_grant();
      eop();
    end
    RD_REQ = 1'b0;
`ifdef SW_RXBUF_SCHED_STAT_EN
    stat_exp = 32'd5;
`else
    stat_exp = 32'd0;
`endif
    check("stat_served", stat3(), 64'(stat_exp));
    STAT_CLR = 1'b1;
    tick();
    STAT_CLR = 1'b0;
    check("stat_clr", stat3(), 64'd0);
    pkt_done(4'b1000);
    exp_q.push_back(3);
    RD_REQ = 1'b1;
    wait_grant();
    RD_REQ = 1'b0;
    RD_EOP = 1'b1;
    STAT_CLR = 1'b1;
    tick();
    RD_EOP = 1'b0;
    STAT_CLR = 1'b0;
    check("stat_clr_wins", stat3(), 64'd0);
    check("stat_others", 64'(STAT_PKTS[3*SW-1:0]), 64'd0);

    tick();
    check("sb_empty", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
